plot_frame_receiver: RTL and testbench
======================================

PLOT_FRAME_RECEIVER -- requirements
Module: plot_frame_receiver

Interface
REQ-001 SHALL have port clk, input, 1, system clock; all logic on its rising edge.
REQ-002 SHALL have port reset_n, input, 1, reset (synchronous, active-low).
REQ-003 SHALL have port x, input, 10, pixel column from a drawing engine.
REQ-004 SHALL have port y, input, 10, pixel row from a drawing engine.
REQ-005 SHALL have port color, input, 3, pixel colour (RGB, 1 bit each).
REQ-006 SHALL have port plot, input, 1, x/y/color valid this cycle; no back-pressure to the drawer.
REQ-007 SHALL have port done_in, input, 1, drawer end-of-sprite pulse.
REQ-008 SHALL have port mem_addr, output, 15, framebuffer word address.
REQ-009 SHALL have port mem_data, output, 3, framebuffer write colour.
REQ-010 SHALL have port mem_we, output, 1, write request; a write completes on a cycle with mem_we=1 and mem_ready=1.
REQ-011 SHALL have port mem_ready, input, 1, framebuffer can accept a write this cycle.
REQ-012 SHALL have port busy, output, 1, high in RECEIVE and DRAIN.
REQ-013 SHALL have port frame_done, output, 1, one-cycle pulse when all pixels of a sprite are written.
REQ-014 SHALL have port overflow, output, 1, sticky flag: a pixel was dropped.
REQ-015 SHALL have port pix_count, output, 16, completed writes, saturating at 65535.
REQ-016 SHALL have port clip_count, output, 16, discarded off-screen pixels, saturating at 65535.

Function
REQ-017 SHALL sample x, y, color on every rising edge with plot=1, with no gaps required between samples.
REQ-018 SHALL discard a sampled pixel with x>=160 or y>=120 and increment clip_count.
REQ-019 SHALL compute, in a one-cycle stage register, address = y*160 + x (= (y<<7)+(y<<5)+x), 15-bit, no multiplier.
REQ-020 SHALL push each valid stage-register entry into a 4-entry FIFO of {addr,color} on the next edge.
REQ-021 SHALL drive mem_we=1 whenever the FIFO is non-empty, with mem_addr/mem_data equal to the FIFO head.
REQ-022 SHALL pop the FIFO and increment pix_count on each completed write.
REQ-023 SHALL give minimum latency with an empty FIFO and mem_ready=1: plot sampled at edge N -> mem_we=1 in the cycle after edge N+1.
REQ-024 SHALL hold mem_addr/mem_data stable while mem_we=1 and mem_ready=0.
REQ-025 SHALL allow a simultaneous push and pop when the FIFO is full; occupancy is then unchanged and nothing is dropped.
REQ-026 SHALL drop a push to a full FIFO with no pop in the same cycle and set overflow (cleared only by reset); the drop is counted in neither counter.
REQ-027 SHALL implement an FSM with states IDLE, RECEIVE, DRAIN, DONE:
- IDLE->RECEIVE on plot=1.
- IDLE or RECEIVE -> DRAIN on done_in=1; done_in has priority over plot in the same cycle, and that plot pixel is still accepted.
- DRAIN->DONE when the stage register is empty, the FIFO is empty, and plot=0.
- DONE->IDLE unconditionally; frame_done=1 only in DONE.
REQ-028 SHALL keep accepting pixels arriving in DRAIN, which delay the exit from DRAIN.
REQ-029 SHALL ignore done_in in DRAIN and DONE.
REQ-030 SHALL drive mem_we=0 when the FIFO is empty.

Reset
REQ-031 SHALL, with reset_n=0 at an edge, set the FSM to IDLE and empty the FIFO and stage register.
REQ-032 SHALL, on that reset, clear mem_we, busy, frame_done, overflow, pix_count, clip_count, mem_addr and mem_data to 0.
REQ-033 SHALL, on reset mid-operation, discard pending pixels with no partial write issued after the reset edge.

Structure
REQ-034 SHALL place SCREEN_W=160, SCREEN_H=120, ADDR_W=15, COLOR_W=3, FIFO_DEPTH=4 and the FSM state encodings in the shared graphics package.
REQ-035 SHALL implement the FIFO as sub-module plot_fifo, with push/pop/full/empty and a synchronous, active-low reset.

Verification
REQ-036 SHALL test: single plot (x=10, y=2, color=7), mem_ready=1 -> mem_addr=330, mem_data=7, mem_we for 1 cycle, pix_count=1.
REQ-037 SHALL test: plot x=160 y=0 and x=0 y=120 -> no mem_we, clip_count=2; then x=159 y=119 -> mem_addr=19199.
REQ-038 SHALL test: 32x64 burst (2048 back-to-back plots at origin 50,50), mem_ready=1, then done_in -> pix_count=2048, overflow=0, a single frame_done.
REQ-039 SHALL test: mem_ready=0 with 6 back-to-back plots -> first 5 retained (4 FIFO + stage), overflow=1; after mem_ready=1 -> pix_count=5 with FIFO-order addresses.
REQ-040 SHALL test: done_in with 3 pixels pending and mem_ready toggling -> frame_done only after the third write, busy low the cycle after.
REQ-041 SHALL test: reset_n=0 for one cycle during a burst -> next cycle mem_we=0, counters=0, FSM=IDLE, overflow=0.

Source files
------------

// File: rtl/plot_frame_receiver_pkg.sv
// Shared graphics definitions: screen geometry, framebuffer widths, FSM encodings
// and small helpers used by the plot receiver and its FIFO.
package plot_frame_receiver_pkg;

    localparam int SCREEN_W   = 160;
    localparam int SCREEN_H   = 120;
    localparam int COORD_W    = 10;
    localparam int ADDR_W     = 15;
    localparam int COLOR_W    = 3;
    localparam int FIFO_DEPTH = 4;
    localparam int COUNT_W    = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RECEIVE = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0]  addr;
        logic [COLOR_W-1:0] color;
    } pixel_t;

    localparam int PIXEL_W = ADDR_W + COLOR_W;

    function automatic logic in_screen(input logic [COORD_W-1:0] px,
                                       input logic [COORD_W-1:0] py);
        return (px < COORD_W'(SCREEN_W)) && (py < COORD_W'(SCREEN_H));
    endfunction

    // y*160 + x built from shifts, since 160 = 128 + 32
    function automatic logic [ADDR_W-1:0] pixel_addr(input logic [COORD_W-1:0] px,
                                                     input logic [COORD_W-1:0] py);
        logic [ADDR_W-1:0] ye;
        logic [ADDR_W-1:0] xe;
        ye = ADDR_W'(py);
        xe = ADDR_W'(px);
        return (ye << 7) + (ye << 5) + xe;
    endfunction

    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
        return (v == '1) ? v : v + COUNT_W'(1);
    endfunction

endpackage

// File: rtl/plot_frame_receiver_fifo.sv
// Small circular FIFO holding pending framebuffer writes; supports push and pop
// in the same cycle, including when full.
module plot_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = DEPTH[PTR_W:0];

    logic [WIDTH-1:0] store [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_COUNT);
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign do_push = push && (!full || do_pop);
    assign dout    = store[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) store[wr_ptr] <= din;
    end

endmodule

// File: rtl/plot_frame_receiver.sv
// Receives plotted pixels from a drawing engine, clips them to the screen,
// converts them to framebuffer addresses and queues the writes.
module plot_frame_receiver
    import plot_frame_receiver_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic [COLOR_W-1:0] color,
    input  logic               plot,
    input  logic               done_in,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [COLOR_W-1:0] mem_data,
    output logic               mem_we,
    input  logic               mem_ready,
    output logic               busy,
    output logic               frame_done,
    output logic               overflow,
    output logic [COUNT_W-1:0] pix_count,
    output logic [COUNT_W-1:0] clip_count
);

    state_t state;
    state_t state_next;

    logic   stage_valid;
    pixel_t stage_pix;
    logic   pix_on_screen;
    logic   stage_stall;
    logic   stage_load;

    logic   fifo_push;
    logic   fifo_pop;
    logic   fifo_full;
    logic   fifo_empty;
    pixel_t fifo_head;

    assign pix_on_screen = in_screen(x, y);
    assign fifo_pop      = !fifo_empty && mem_ready;
    // The stage keeps its pixel while the FIFO cannot take it; a new pixel
    // arriving then is the one that gets dropped.
    assign stage_stall   = stage_valid && fifo_full && !fifo_pop;
    assign fifo_push     = stage_valid && !stage_stall;
    assign stage_load    = plot && pix_on_screen && !stage_stall;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stage_valid <= 1'b0;
            stage_pix   <= '0;
        end else if (!stage_stall) begin
            stage_valid <= stage_load;
            if (stage_load) begin
                stage_pix.addr  <= pixel_addr(x, y);
                stage_pix.color <= color;
            end
        end
    end

    plot_fifo #(
        .WIDTH (PIXEL_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .din     (stage_pix),
        .dout    (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign mem_we   = !fifo_empty;
    assign mem_addr = fifo_empty ? '0 : fifo_head.addr;
    assign mem_data = fifo_empty ? '0 : fifo_head.color;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pix_count  <= '0;
            clip_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (fifo_pop)                   pix_count  <= sat_inc(pix_count);
            if (plot && !pix_on_screen)     clip_count <= sat_inc(clip_count);
            if (plot && pix_on_screen && stage_stall) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_next;
    end

    // done_in outranks plot; late pixels in DRAIN hold off the DONE pulse
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        frame_done = 1'b0;
        case (state)
            ST_IDLE: begin
                if (done_in)   state_next = ST_DRAIN;
                else if (plot) state_next = ST_RECEIVE;
            end
            ST_RECEIVE: begin
                busy = 1'b1;
                if (done_in) state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if (!stage_valid && fifo_empty && !plot) state_next = ST_DONE;
            end
            ST_DONE: begin
                frame_done = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_plot_frame_receiver.sv
// Directed self-checking bench for plot_frame_receiver.
module tb_plot_frame_receiver;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [9:0]  x = '0;
    logic [9:0]  y = '0;
    logic [2:0]  color = '0;
    logic        plot = 1'b0;
    logic        done_in = 1'b0;
    logic [14:0] mem_addr;
    logic [2:0]  mem_data;
    logic        mem_we;
    logic        mem_ready = 1'b1;
    logic        busy;
    logic        frame_done;
    logic        overflow;
    logic [15:0] pix_count;
    logic [15:0] clip_count;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    int we_cycles = 0;
    int fd_count = 0;
    int fd_cyc = 0;
    logic [17:0] wr_q[$];
    int          wr_cyc_q[$];

    plot_frame_receiver dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .x          (x),
        .y          (y),
        .color      (color),
        .plot       (plot),
        .done_in    (done_in),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_we     (mem_we),
        .mem_ready  (mem_ready),
        .busy       (busy),
        .frame_done (frame_done),
        .overflow   (overflow),
        .pix_count  (pix_count),
        .clip_count (clip_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record completed writes and frame_done pulses mid-cycle
    always @(negedge clk) begin
        if (mem_we) we_cycles++;
        if (mem_we && mem_ready) begin
            wr_q.push_back({mem_addr, mem_data});
            wr_cyc_q.push_back(cyc);
        end
        if (frame_done) begin
            fd_count++;
            fd_cyc = cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_monitor();
        we_cycles = 0;
        fd_count  = 0;
        fd_cyc    = 0;
        wr_q.delete();
        wr_cyc_q.delete();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        plot    = 1'b0;
        done_in = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        clear_monitor();
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        mem_ready = 1'b1;
        tick();
        tick();
        tests_run++; if (mem_we !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_mem_we: got %0b expected 0", mem_we); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy: got %0b expected 0", busy); end
        tests_run++; if (frame_done !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_frame_done: got %0b expected 0", frame_done); end
        tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_overflow: got %0b expected 0", overflow); end
        tests_run++; if (pix_count !== 16'd0) begin tests_failed++; $display("[TB] FAIL reset_pix_count: got %0d expected 0", pix_count); end
        tests_run++; if (clip_count !== 16'd0) begin tests_failed++; $display("[TB] FAIL reset_clip_count: got %0d expected 0", clip_count); end
        tests_run++; if (mem_addr !== 15'd0 || mem_data !== 3'd0) begin tests_failed++; $display("[TB] FAIL reset_mem_bus: got addr %0d data %0d expected 0/0", mem_addr, mem_data); end
        reset_n = 1'b1;
        clear_monitor();
    endtask

    task automatic test_single_plot();
        do_reset();
        mem_ready = 1'b1;
        x = 10'd10; y = 10'd2; color = 3'd7; plot = 1'b1;
        tick();
        plot = 1'b0;
        tests_run++; if (mem_we !== 1'b0) begin tests_failed++; $display("[TB] FAIL single_early_we: got %0b expected 0", mem_we); end
        tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL single_busy: got %0b expected 1", busy); end
        tick();
        tests_run++; if (mem_we !== 1'b1) begin tests_failed++; $display("[TB] FAIL single_we: got %0b expected 1", mem_we); end
        tests_run++; if (mem_addr !== 15'd330) begin tests_failed++; $display("[TB] FAIL single_addr: got %0d expected 330", mem_addr); end
        tests_run++; if (mem_data !== 3'd7) begin tests_failed++; $display("[TB] FAIL single_data: got %0d expected 7", mem_data); end
        tick();
        tests_run++; if (mem_we !== 1'b0) begin tests_failed++; $display("[TB] FAIL single_we_drop: got %0b expected 0", mem_we); end
        tests_run++; if (pix_count !== 16'd1) begin tests_failed++; $display("[TB] FAIL single_pix_count: got %0d expected 1", pix_count); end
        tests_run++; if (we_cycles !== 1) begin tests_failed++; $display("[TB] FAIL single_we_cycles: got %0d expected 1", we_cycles); end
    endtask

    task automatic test_clip();
        do_reset();
        mem_ready = 1'b1;
        x = 10'd160; y = 10'd0; color = 3'd5; plot = 1'b1;
        tick();
        x = 10'd0; y = 10'd120;
        tick();
        plot = 1'b0;
        tick(); tick(); tick();
        tests_run++; if (we_cycles !== 0) begin tests_failed++; $display("[TB] FAIL clip_no_we: got %0d expected 0", we_cycles); end
        tests_run++; if (clip_count !== 16'd2) begin tests_failed++; $display("[TB] FAIL clip_count: got %0d expected 2", clip_count); end
        tests_run++; if (pix_count !== 16'd0) begin tests_failed++; $display("[TB] FAIL clip_pix_count: got %0d expected 0", pix_count); end
        x = 10'd159; y = 10'd119; color = 3'd3; plot = 1'b1;
        tick();
        plot = 1'b0;
        tick();
        tests_run++; if (mem_we !== 1'b1) begin tests_failed++; $display("[TB] FAIL corner_we: got %0b expected 1", mem_we); end
        tests_run++; if (mem_addr !== 15'd19199) begin tests_failed++; $display("[TB] FAIL corner_addr: got %0d expected 19199", mem_addr); end
        tests_run++; if (mem_data !== 3'd3) begin tests_failed++; $display("[TB] FAIL corner_data: got %0d expected 3", mem_data); end
        tick();
        tests_run++; if (pix_count !== 16'd1 || clip_count !== 16'd2) begin tests_failed++; $display("[TB] FAIL corner_counts: got pix %0d clip %0d expected 1/2", pix_count, clip_count); end
    endtask

    task automatic test_back_to_back();
        int errs;
        logic [17:0] exp_w;
        do_reset();
        mem_ready = 1'b1;
        for (int yy = 0; yy < 64; yy++) begin
            for (int xx = 0; xx < 32; xx++) begin
                x = 10'(50 + xx); y = 10'(50 + yy); color = 3'(xx + yy); plot = 1'b1;
                tick();
            end
        end
        plot = 1'b0; done_in = 1'b1;
        tick();
        done_in = 1'b0;
        for (int i = 0; i < 50 && fd_count == 0; i++) tick();
        tick(); tick(); tick();
        tests_run++; if (fd_count !== 1) begin tests_failed++; $display("[TB] FAIL burst_frame_done: got %0d pulses expected 1", fd_count); end
        tests_run++; if (pix_count !== 16'd2048) begin tests_failed++; $display("[TB] FAIL burst_pix_count: got %0d expected 2048", pix_count); end
        tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("[TB] FAIL burst_overflow: got %0b expected 0", overflow); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL burst_busy_end: got %0b expected 0", busy); end
        tests_run++; if (wr_q.size() !== 2048) begin tests_failed++; $display("[TB] FAIL burst_writes: got %0d expected 2048", wr_q.size()); end
        errs = 0;
        for (int i = 0; i < wr_q.size() && i < 2048; i++) begin
            exp_w = {15'((50 + i / 32) * 160 + 50 + i % 32), 3'(i % 32 + i / 32)};
            if (wr_q[i] !== exp_w) errs++;
        end
        tests_run++; if (errs !== 0) begin tests_failed++; $display("[TB] FAIL burst_order: got %0d wrong writes expected 0", errs); end
    endtask

    task automatic test_overflow();
        int errs;
        do_reset();
        mem_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            x = 10'(i); y = 10'd1; color = 3'(i + 1); plot = 1'b1;
            tick();
        end
        plot = 1'b0;
        tick(); tick();
        tests_run++; if (overflow !== 1'b1) begin tests_failed++; $display("[TB] FAIL ovf_flag: got %0b expected 1", overflow); end
        tests_run++; if (mem_we !== 1'b1 || mem_addr !== 15'd160 || mem_data !== 3'd1) begin tests_failed++; $display("[TB] FAIL ovf_head_hold: got we %0b addr %0d data %0d expected 1/160/1", mem_we, mem_addr, mem_data); end
        tests_run++; if (pix_count !== 16'd0) begin tests_failed++; $display("[TB] FAIL ovf_no_write: got %0d expected 0", pix_count); end
        mem_ready = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        tests_run++; if (pix_count !== 16'd5) begin tests_failed++; $display("[TB] FAIL ovf_pix_count: got %0d expected 5", pix_count); end
        tests_run++; if (wr_q.size() !== 5) begin tests_failed++; $display("[TB] FAIL ovf_writes: got %0d expected 5", wr_q.size()); end
        errs = 0;
        for (int i = 0; i < wr_q.size() && i < 5; i++)
            if (wr_q[i] !== {15'(160 + i), 3'(i + 1)}) errs++;
        tests_run++; if (errs !== 0) begin tests_failed++; $display("[TB] FAIL ovf_order: got %0d wrong writes expected 0", errs); end
        tests_run++; if (overflow !== 1'b1 || mem_we !== 1'b0) begin tests_failed++; $display("[TB] FAIL ovf_sticky: got ovf %0b we %0b expected 1/0", overflow, mem_we); end
        tests_run++; if (clip_count !== 16'd0) begin tests_failed++; $display("[TB] FAIL ovf_clip_count: got %0d expected 0", clip_count); end
    endtask

    task automatic test_drain();
        int errs;
        int last_wr;
        logic saw_fd;
        do_reset();
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            x = 10'(20 + i); y = 10'd3; color = 3'(i + 2); plot = 1'b1;
            tick();
        end
        plot = 1'b0; done_in = 1'b1;
        tick();
        done_in = 1'b0;
        tests_run++; if (busy !== 1'b1 || frame_done !== 1'b0) begin tests_failed++; $display("[TB] FAIL drain_entry: got busy %0b fd %0b expected 1/0", busy, frame_done); end
        saw_fd = 1'b0;
        for (int i = 0; i < 40 && !saw_fd; i++) begin
            mem_ready = ~mem_ready;
            tick();
            if (frame_done === 1'b1) begin
                saw_fd = 1'b1;
                tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL drain_busy_at_done: got %0b expected 0", busy); end
            end
        end
        tests_run++; if (saw_fd !== 1'b1) begin tests_failed++; $display("[TB] FAIL drain_timeout: got no frame_done expected one within 40 cycles"); end
        tick();
        tests_run++; if (busy !== 1'b0 || frame_done !== 1'b0) begin tests_failed++; $display("[TB] FAIL drain_after: got busy %0b fd %0b expected 0/0", busy, frame_done); end
        tests_run++; if (wr_q.size() !== 3 || pix_count !== 16'd3) begin tests_failed++; $display("[TB] FAIL drain_writes: got %0d/%0d expected 3/3", wr_q.size(), pix_count); end
        last_wr = (wr_cyc_q.size() >= 3) ? wr_cyc_q[2] : 32'h3fffffff;
        tests_run++; if ((fd_cyc > last_wr) !== 1'b1) begin tests_failed++; $display("[TB] FAIL drain_fd_order: got fd cycle %0d last write %0d expected fd later", fd_cyc, last_wr); end
        tests_run++; if (fd_count !== 1) begin tests_failed++; $display("[TB] FAIL drain_fd_count: got %0d expected 1", fd_count); end
        errs = 0;
        for (int i = 0; i < wr_q.size() && i < 3; i++)
            if (wr_q[i] !== {15'(500 + i), 3'(i + 2)}) errs++;
        tests_run++; if (errs !== 0) begin tests_failed++; $display("[TB] FAIL drain_order: got %0d wrong writes expected 0", errs); end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        mem_ready = 1'b0;
        x = 10'd200; y = 10'd5; color = 3'd1; plot = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            x = 10'(i); y = 10'd7; color = 3'(i); plot = 1'b1;
            tick();
        end
        tests_run++; if (overflow !== 1'b1 || clip_count !== 16'd1) begin tests_failed++; $display("[TB] FAIL midrst_setup: got ovf %0b clip %0d expected 1/1", overflow, clip_count); end
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1; plot = 1'b0; mem_ready = 1'b1;
        clear_monitor();
        tests_run++; if (mem_we !== 1'b0) begin tests_failed++; $display("[TB] FAIL midrst_we: got %0b expected 0", mem_we); end
        tests_run++; if (pix_count !== 16'd0 || clip_count !== 16'd0) begin tests_failed++; $display("[TB] FAIL midrst_counts: got %0d/%0d expected 0/0", pix_count, clip_count); end
        tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("[TB] FAIL midrst_overflow: got %0b expected 0", overflow); end
        tests_run++; if (busy !== 1'b0 || frame_done !== 1'b0) begin tests_failed++; $display("[TB] FAIL midrst_idle: got busy %0b fd %0b expected 0/0", busy, frame_done); end
        tick(); tick(); tick(); tick();
        tests_run++; if (we_cycles !== 0 || pix_count !== 16'd0) begin tests_failed++; $display("[TB] FAIL midrst_no_write: got we %0d pix %0d expected 0/0", we_cycles, pix_count); end
    endtask

    initial begin
        test_reset();
        test_single_plot();
        test_clip();
        test_back_to_back();
        test_overflow();
        test_drain();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
